// File: rtl/rgmii_ctrl_pkg.sv
// Shared constants for the RGMII link-speed sequencer: speed codes, FSM state codes
// and the request normalisation helper.
package rgmii_ctrl_pkg;

    localparam logic [1:0] SPEED_10M  = 2'b00;
    localparam logic [1:0] SPEED_100M = 2'b01;
    localparam logic [1:0] SPEED_1G   = 2'b10;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_DRAIN  = 3'd1;
    localparam state_t ST_HOLD   = 3'd2;
    localparam state_t ST_SWITCH = 3'd3;
    localparam state_t ST_SETTLE = 3'd4;
    localparam state_t ST_DONE   = 3'd5;

    // 2'b11 has no meaning on the PHY side; treat it as gigabit.
    function automatic logic [1:0] normalise_speed(input logic [1:0] s);
        return s[1] ? SPEED_1G : s;
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/rgmii_speed_ctrl_timer.sv
// Loadable down-counter shared by the drain timeout, PHY-reset hold and settle phases.
// expired is high whenever the count has reached zero.
module rgmii_speed_ctrl_timer #(
    parameter int W = 13
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_value,
    input  logic         enable,
    output logic         expired
);

    logic [W-1:0] count_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_value;
        end else if (enable && (count_reg != '0)) begin
            count_reg <= count_reg - 1'b1;
        end
    end

    assign expired = (count_reg == '0);

endmodule

// File: rtl/rgmii_speed_ctrl.sv
// Link-speed change sequencer: drains the MAC to a frame boundary, resets the PHY
// interface around the speed switch, then settles. Optional stats via RGMII_SPEED_STATS_EN.
module rgmii_speed_ctrl
    import rgmii_ctrl_pkg::*;
#(
    parameter logic [1:0] RESET_SPEED   = 2'b10,
    parameter int         RST_CYCLES    = 2,
    parameter int         SETTLE_CYCLES = 16,
    parameter int         DRAIN_TIMEOUT = 4096,
    parameter int         CNT_W         = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    input  logic [1:0]       req_speed,
    output logic             req_ready,
    input  logic             mac_tx_en,
    input  logic             mac_tx_clk_en,
    output logic [1:0]       speed,
    output logic             phy_if_rst,
    output logic             mac_tx_hold,
    output logic             busy,
    output logic             done,
    output logic             timeout_err,
    output logic [CNT_W-1:0] switch_count,
    output logic [CNT_W-1:0] cyc_10m,
    output logic [CNT_W-1:0] cyc_100m,
    output logic [CNT_W-1:0] cyc_1g,
    output logic [CNT_W-1:0] cyc_total
);

    localparam int TMR_W = $clog2(max3(DRAIN_TIMEOUT, SETTLE_CYCLES, RST_CYCLES) + 1);

    state_t           state_reg, state_next;
    logic [1:0]       target_reg;
    logic [1:0]       speed_reg;
    logic             phy_if_rst_reg;
    logic             mac_tx_hold_reg;
    logic             done_reg;
    logic [CNT_W-1:0] switch_count_reg;

    logic             boundary;
    logic [1:0]       req_norm;
    logic             accept;
    logic             noop;
    logic             tmr_load;
    logic [TMR_W-1:0] tmr_load_value;
    logic             tmr_enable;
    logic             tmr_expired;

    assign boundary = mac_tx_clk_en && !mac_tx_en;
    assign req_norm = normalise_speed(req_speed);

    always_comb begin
        state_next     = state_reg;
        accept         = 1'b0;
        noop           = 1'b0;
        tmr_load       = 1'b0;
        tmr_load_value = '0;
        case (state_reg)
            ST_IDLE: begin
                if (req_valid) begin
                    accept = 1'b1;
                    if (req_norm == speed_reg) begin
                        noop = 1'b1;
                    end else begin
                        state_next     = ST_DRAIN;
                        tmr_load       = 1'b1;
                        tmr_load_value = TMR_W'(DRAIN_TIMEOUT - 1);
                    end
                end
            end
            ST_DRAIN: begin
                if (boundary || tmr_expired) begin
                    state_next     = ST_HOLD;
                    tmr_load       = 1'b1;
                    tmr_load_value = TMR_W'(RST_CYCLES - 1);
                end
            end
            ST_HOLD: begin
                if (tmr_expired) state_next = ST_SWITCH;
            end
            ST_SWITCH: begin
                state_next     = ST_SETTLE;
                tmr_load       = 1'b1;
                tmr_load_value = TMR_W'(SETTLE_CYCLES - 1);
            end
            ST_SETTLE: begin
                if (tmr_expired) state_next = ST_DONE;
            end
            ST_DONE:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    assign tmr_enable = (state_reg == ST_DRAIN) || (state_reg == ST_HOLD) ||
                        (state_reg == ST_SETTLE);

    rgmii_speed_ctrl_timer #(
        .W (TMR_W)
    ) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (tmr_load),
        .load_value (tmr_load_value),
        .enable     (tmr_enable),
        .expired    (tmr_expired)
    );

    // Outputs are registered from the next state so they line up with the state cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg        <= ST_IDLE;
            target_reg       <= RESET_SPEED;
            speed_reg        <= RESET_SPEED;
            phy_if_rst_reg   <= 1'b1;
            mac_tx_hold_reg  <= 1'b1;
            done_reg         <= 1'b0;
            switch_count_reg <= '0;
        end else begin
            state_reg       <= state_next;
            phy_if_rst_reg  <= (state_next == ST_HOLD) || (state_next == ST_SWITCH);
            mac_tx_hold_reg <= (state_next != ST_IDLE);
            done_reg        <= noop || (state_next == ST_DONE);
            if (accept) begin
                target_reg <= req_norm;
            end
            if (state_reg == ST_SWITCH) begin
                speed_reg <= target_reg;
            end
            if ((state_next == ST_DONE) && (switch_count_reg != {CNT_W{1'b1}})) begin
                switch_count_reg <= switch_count_reg + 1'b1;
            end
        end
    end

    assign req_ready    = (state_reg == ST_IDLE);
    assign busy         = (state_reg != ST_IDLE);
    assign speed        = speed_reg;
    assign phy_if_rst   = phy_if_rst_reg;
    assign mac_tx_hold  = mac_tx_hold_reg;
    assign done         = done_reg;
    assign switch_count = switch_count_reg;
    assign timeout_err  = (state_reg == ST_DRAIN) && tmr_expired && !boundary;

`ifdef RGMII_SPEED_STATS_EN
    logic [CNT_W-1:0] cyc_10m_reg, cyc_100m_reg, cyc_1g_reg, cyc_total_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc_10m_reg   <= '0;
            cyc_100m_reg  <= '0;
            cyc_1g_reg    <= '0;
            cyc_total_reg <= '0;
        end else begin
            if (cyc_total_reg != {CNT_W{1'b1}}) cyc_total_reg <= cyc_total_reg + 1'b1;
            case (speed_reg)
                SPEED_10M: begin
                    if (cyc_10m_reg != {CNT_W{1'b1}}) cyc_10m_reg <= cyc_10m_reg + 1'b1;
                end
                SPEED_100M: begin
                    if (cyc_100m_reg != {CNT_W{1'b1}}) cyc_100m_reg <= cyc_100m_reg + 1'b1;
                end
                default: begin
                    if (cyc_1g_reg != {CNT_W{1'b1}}) cyc_1g_reg <= cyc_1g_reg + 1'b1;
                end
            endcase
        end
    end

    assign cyc_10m   = cyc_10m_reg;
    assign cyc_100m  = cyc_100m_reg;
    assign cyc_1g    = cyc_1g_reg;
    assign cyc_total = cyc_total_reg;

`ifdef FORMAL
    always_comb begin
        assert (cyc_10m_reg <= cyc_total_reg);
        assert (cyc_100m_reg <= cyc_total_reg);
        assert (cyc_1g_reg <= cyc_total_reg);
    end
`endif
`else
    assign cyc_10m   = '0;
    assign cyc_100m  = '0;
    assign cyc_1g    = '0;
    assign cyc_total = '0;
`endif

endmodule

// File: tb/tb_rgmii_speed_ctrl.sv
// Self-checking bench for rgmii_speed_ctrl: randomized requests and MAC activity
// compared cycle by cycle against a timeline model of the speed-change sequence.
module tb_rgmii_speed_ctrl;

    localparam int         RST_C    = 2;
    localparam int         SETTLE_C = 16;
    localparam int         DT       = 128;
    localparam int         CW       = 12;
    localparam logic [1:0] RS       = 2'b10;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid = 1'b0;
    logic [1:0]    req_speed = 2'b00;
    logic          req_ready;
    logic          mac_tx_en = 1'b0;
    logic          mac_tx_clk_en = 1'b1;
    logic [1:0]    speed;
    logic          phy_if_rst;
    logic          mac_tx_hold;
    logic          busy;
    logic          done;
    logic          timeout_err;
    logic [CW-1:0] switch_count;
    logic [CW-1:0] cyc_10m, cyc_100m, cyc_1g, cyc_total;

    int            tests = 0;
    int            fails = 0;
    logic [1:0]    cur_m = RS;
    int            count_m = 0;

    rgmii_speed_ctrl #(
        .RESET_SPEED   (RS),
        .RST_CYCLES    (RST_C),
        .SETTLE_CYCLES (SETTLE_C),
        .DRAIN_TIMEOUT (DT),
        .CNT_W         (CW)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_speed     (req_speed),
        .req_ready     (req_ready),
        .mac_tx_en     (mac_tx_en),
        .mac_tx_clk_en (mac_tx_clk_en),
        .speed         (speed),
        .phy_if_rst    (phy_if_rst),
        .mac_tx_hold   (mac_tx_hold),
        .busy          (busy),
        .done          (done),
        .timeout_err   (timeout_err),
        .switch_count  (switch_count),
        .cyc_10m       (cyc_10m),
        .cyc_100m      (cyc_100m),
        .cyc_1g        (cyc_1g),
        .cyc_total     (cyc_total)
    );

    always #5 clk = ~clk;

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        tests++;
        if (speed !== RS || phy_if_rst !== 1'b1 || mac_tx_hold !== 1'b1 || busy !== 1'b0 ||
            done !== 1'b0 || timeout_err !== 1'b0 || switch_count !== '0) begin
            fails++;
            $display("FAIL reset_values: got spd=%b rst=%b hold=%b busy=%b done=%b to=%b cnt=%0d want spd=%b rst=1 hold=1 busy=0 done=0 to=0 cnt=0",
                     speed, phy_if_rst, mac_tx_hold, busy, done, timeout_err, switch_count, RS);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        tests++;
        if (phy_if_rst !== 1'b0 || mac_tx_hold !== 1'b0) begin
            fails++;
            $display("FAIL reset_first_clk: got rst=%b hold=%b want 0 0", phy_if_rst, mac_tx_hold);
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #1;
            tests++;
            if (speed !== RS || busy !== 1'b0 || phy_if_rst !== 1'b0 || mac_tx_hold !== 1'b0 ||
                req_ready !== 1'b1) begin
                fails++;
                $display("FAIL reset_idle c%0d: got spd=%b busy=%b rst=%b hold=%b rdy=%b want %b 0 0 0 1",
                         i, speed, busy, phy_if_rst, mac_tx_hold, req_ready, RS);
            end
        end
        $display("[TB] reset: speed=%b idle", speed);
        cur_m   = RS;
        count_m = 0;
    endtask

    // One request; the model derives every event cycle from the drain end cycle d.
    task automatic run_request(input logic [1:0] req, input int txb, input bit rnd, input string tag);
        logic [1:0]    tgt;
        bit            tx[256];
        bit            ce[256];
        int            d;
        int            done_off;
        bit            forced;
        bit            e_busy, e_rst, e_done, e_to;
        logic [1:0]    e_speed;
        logic [CW-1:0] e_cnt;

        tgt = (req == 2'b11) ? 2'b10 : req;
        @(negedge clk);
        req_valid     = 1'b1;
        req_speed     = req;
        mac_tx_en     = 1'b0;
        mac_tx_clk_en = 1'b1;
        #1;
        tests++;
        if (req_ready !== 1'b1 || busy !== 1'b0 || mac_tx_hold !== 1'b0) begin
            fails++;
            $display("FAIL %s accept: got rdy=%b busy=%b hold=%b want 1 0 0", tag, req_ready, busy, mac_tx_hold);
        end

        if (tgt == cur_m) begin
            @(negedge clk);
            req_valid = 1'b0;
            #1;
            tests++;
            if (done !== 1'b1 || busy !== 1'b0 || mac_tx_hold !== 1'b0 || speed !== cur_m ||
                switch_count !== CW'(count_m)) begin
                fails++;
                $display("FAIL %s noop_n1: got done=%b busy=%b hold=%b spd=%b cnt=%0d want 1 0 0 %b %0d",
                         tag, done, busy, mac_tx_hold, speed, switch_count, cur_m, count_m);
            end
            @(negedge clk);
            #1;
            tests++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                fails++;
                $display("FAIL %s noop_n2: got done=%b busy=%b want 0 0", tag, done, busy);
            end
            $display("[TB] %s: req=%b no-op, speed=%b count=%0d", tag, req, speed, switch_count);
            return;
        end

        for (int i = 0; i < 256; i++) begin
            tx[i] = (i <= txb) ? 1'b1 : (rnd ? 1'($urandom_range(0, 1)) : 1'b0);
            ce[i] = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
        d = DT;
        for (int i = 1; i <= DT; i++) begin
            if (ce[i] && !tx[i]) begin
                d = i;
                break;
            end
        end
        forced   = !(ce[d] && !tx[d]);
        done_off = d + RST_C + 2 + SETTLE_C;

        for (int i = 1; i <= done_off + 1; i++) begin
            @(negedge clk);
            req_valid     = (i <= done_off) ? 1'($urandom_range(0, 1)) : 1'b0;
            req_speed     = 2'($urandom_range(0, 3));
            mac_tx_en     = tx[i];
            mac_tx_clk_en = ce[i];
            #1;
            e_busy  = (i <= done_off);
            e_rst   = (i >= d + 1) && (i <= d + RST_C + 1);
            e_speed = (i >= d + RST_C + 2) ? tgt : cur_m;
            e_done  = (i == done_off);
            e_to    = forced && (i == d);
            e_cnt   = CW'(count_m + ((i >= done_off) ? 1 : 0));
            tests++;
            if (busy !== e_busy || req_ready !== !e_busy || mac_tx_hold !== e_busy) begin
                fails++;
                $display("FAIL %s busy_hold @+%0d: got busy=%b rdy=%b hold=%b want busy=%b",
                         tag, i, busy, req_ready, mac_tx_hold, e_busy);
            end
            tests++;
            if (phy_if_rst !== e_rst) begin
                fails++;
                $display("FAIL %s phy_if_rst @+%0d: got %b want %b", tag, i, phy_if_rst, e_rst);
            end
            tests++;
            if (speed !== e_speed) begin
                fails++;
                $display("FAIL %s speed @+%0d: got %b want %b", tag, i, speed, e_speed);
            end
            tests++;
            if (done !== e_done || timeout_err !== e_to) begin
                fails++;
                $display("FAIL %s done_to @+%0d: got done=%b to=%b want done=%b to=%b",
                         tag, i, done, timeout_err, e_done, e_to);
            end
            tests++;
            if (switch_count !== e_cnt) begin
                fails++;
                $display("FAIL %s switch_count @+%0d: got %0d want %0d", tag, i, switch_count, e_cnt);
            end
`ifdef RGMII_SPEED_STATS_EN
            tests++;
            if (int'(cyc_10m) + int'(cyc_100m) + int'(cyc_1g) !== int'(cyc_total)) begin
                fails++;
                $display("FAIL %s stats_sum @+%0d: got %0d+%0d+%0d want %0d",
                         tag, i, cyc_10m, cyc_100m, cyc_1g, cyc_total);
            end
`else
            tests++;
            if ({cyc_10m, cyc_100m, cyc_1g, cyc_total} !== '0) begin
                fails++;
                $display("FAIL %s stats_off @+%0d: got %0d %0d %0d %0d want 0", tag, i,
                         cyc_10m, cyc_100m, cyc_1g, cyc_total);
            end
`endif
        end
        cur_m = tgt;
        count_m++;
        $display("[TB] %s: req=%b drain_end=+%0d forced=%0d done=+%0d speed=%b count=%0d",
                 tag, req, d, forced, done_off, speed, switch_count);
    endtask

    task automatic test_noop();
        run_request(2'b11, 0, 1'b0, "noop_11");
    endtask

    task automatic test_switch_idle();
        run_request(2'b00, 0, 1'b0, "switch_idle");
        run_request(2'b00, 0, 1'b0, "noop_same");
    endtask

    task automatic test_drain_hold();
        run_request(2'b01, 100, 1'b0, "drain_hold");
    endtask

    task automatic test_timeout();
        run_request(2'b10, DT + 20, 1'b0, "timeout");
    endtask

    task automatic test_random();
        for (int k = 0; k < 8; k++) begin
            run_request(2'($urandom_range(0, 3)), $urandom_range(0, 20), 1'b1, "random");
        end
    endtask

    task automatic test_reset_mid();
        logic [1:0] tgt;
        tgt = (cur_m == 2'b00) ? 2'b01 : 2'b00;
        @(negedge clk);
        req_valid     = 1'b1;
        req_speed     = tgt;
        mac_tx_en     = 1'b0;
        mac_tx_clk_en = 1'b1;
        // Idle MAC: drain ends at +1, so +8 lands inside the settle window.
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            req_valid = 1'b0;
        end
        #1;
        tests++;
        if (speed !== tgt || busy !== 1'b1 || phy_if_rst !== 1'b0 || mac_tx_hold !== 1'b1) begin
            fails++;
            $display("FAIL mid_settle: got spd=%b busy=%b rst=%b hold=%b want %b 1 0 1",
                     speed, busy, phy_if_rst, mac_tx_hold, tgt);
        end
        #2;
        rst_n = 1'b0;
        #1;
        tests++;
        if (speed !== RS || phy_if_rst !== 1'b1 || mac_tx_hold !== 1'b1 || busy !== 1'b0 ||
            done !== 1'b0 || switch_count !== '0) begin
            fails++;
            $display("FAIL mid_async_reset: got spd=%b rst=%b hold=%b busy=%b done=%b cnt=%0d want %b 1 1 0 0 0",
                     speed, phy_if_rst, mac_tx_hold, busy, done, switch_count, RS);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        cur_m   = RS;
        count_m = 0;
        @(negedge clk);
        #1;
        tests++;
        if (phy_if_rst !== 1'b0 || mac_tx_hold !== 1'b0 || speed !== RS) begin
            fails++;
            $display("FAIL mid_release: got rst=%b hold=%b spd=%b want 0 0 %b", phy_if_rst, mac_tx_hold, speed, RS);
        end
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            #1;
            tests++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                fails++;
                $display("FAIL mid_no_done c%0d: got done=%b busy=%b want 0 0", i, done, busy);
            end
        end
        $display("[TB] reset_mid: abandoned switch to %b, speed=%b", tgt, speed);
        run_request(2'b01, 3, 1'b1, "after_reset");
    endtask

    initial begin
        test_reset();
        test_noop();
        test_switch_idle();
        test_drain_hold();
        test_timeout();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/rgmii_speed_ctrl.md
Name: rgmii_speed_ctrl

Overview:
- Sequences link-speed changes for the RGMII PHY interface block, which consumes a 2-bit `speed` select (00=10M, 01=100M, 1x=1000M).
- Accepts a speed-change request and stalls the MAC at a frame boundary.
- Holds the PHY interface in reset while `speed` is switched, then waits a settle period before releasing the MAC.
- Sits between the management/autoneg logic and the PHY interface, in the `clk` (tx) domain.

Parameters:
- RESET_SPEED, 2'b10, value driven on `speed` out of reset.
- RST_CYCLES, 2, cycles `phy_if_rst` is held before `speed` changes (min 1).
- SETTLE_CYCLES, 16, cycles after reset release before the MAC is released (min 1).
- DRAIN_TIMEOUT, 4096, max cycles spent waiting for a frame boundary.
- CNT_W, 12, width of the statistics and switch counters.

Ports:
- clk  in  1  system/tx clock; all logic is synchronous to it.
- rst_n  in  1  reset, asynchronous assert, active-low.
- req_valid  in  1  speed-change request.
- req_speed  in  2  requested speed; 2'b11 is normalised to 2'b10.
- req_ready  out  1  high only in IDLE.
- mac_tx_en  in  1  GMII tx_en from the MAC (monitored only).
- mac_tx_clk_en  in  1  GMII clock enable from the PHY interface.
- speed  out  2  speed select to the PHY interface.
- phy_if_rst  out  1  active-high reset to the PHY interface.
- mac_tx_hold  out  1  MAC must not start a new frame while high.
- busy  out  1  high whenever state != IDLE.
- done  out  1  1-cycle pulse when a request completes.
- timeout_err  out  1  1-cycle pulse when the drain timeout forces a switch.
- switch_count  out  CNT_W  number of completed real switches; saturates at all-ones.
- cyc_10m, cyc_100m, cyc_1g  out  CNT_W each  per-speed cycle counters (see Optional Feature).
- cyc_total  out  CNT_W  global cycle counter (see Optional Feature).

Behaviour:
- Reset (rst_n=0, asynchronous) forces these values:
  - state=IDLE, speed=RESET_SPEED.
  - phy_if_rst=1, mac_tx_hold=1.
  - done=0, timeout_err=0, all counters=0.
- First clock after rst_n rises: phy_if_rst=0 and mac_tx_hold=0.
- Reset mid-operation abandons the request; no done pulse is issued.
- FSM states: IDLE, DRAIN, HOLD, SWITCH, SETTLE, DONE.
- IDLE:
  - req_ready=1.
  - On req_valid, capture the normalised target.
  - If target==speed: no-op; done pulses next cycle, state stays IDLE, switch_count is unchanged.
  - Otherwise go to DRAIN with mac_tx_hold=1 from the next cycle.
- DRAIN:
  - Go to HOLD on the first cycle where mac_tx_clk_en=1 and mac_tx_en=0.
  - If the DRAIN_TIMEOUT count expires first, go to HOLD anyway and pulse timeout_err in that same transition cycle.
- HOLD: phy_if_rst=1 for RST_CYCLES cycles, then go to SWITCH.
- SWITCH: 1 cycle, phy_if_rst=1; speed<=target, visible from the next cycle.
- SETTLE: phy_if_rst=0, mac_tx_hold=1, lasts SETTLE_CYCLES cycles.
- DONE: 1 cycle; done=1, switch_count += 1 (saturating), mac_tx_hold deasserts next cycle, return to IDLE.
- Latency with an idle MAC and request accepted in cycle N:
  - DRAIN at N+1, HOLD at N+2..N+1+RST_CYCLES, SWITCH at N+2+RST_CYCLES.
  - speed changes at N+3+RST_CYCLES.
  - done at N+3+RST_CYCLES+SETTLE_CYCLES; N+21 with defaults.
- Requests while busy are ignored (req_ready=0); requesters hold req_valid.
- speed never changes except from SWITCH or reset.
- phy_if_rst is never high while mac_tx_hold is low.
- Counters saturate and do not wrap.

Optional Feature:
- Macro: RGMII_SPEED_STATS_EN.
- Defined:
  - cyc_total increments every cycle after reset.
  - Exactly one of cyc_10m, cyc_100m, cyc_1g increments each cycle, selected by the current `speed`.
  - All four saturate at all-ones.
  - Invariant: cyc_10m+cyc_100m+cyc_1g == cyc_total until any counter saturates.
  - Under FORMAL, assert each per-speed counter <= cyc_total.
- Undefined: all four outputs tied to 0; no registers inferred.

Decomposition:
- Package rgmii_ctrl_pkg holds:
  - SPEED_10M=2'b00, SPEED_100M=2'b01, SPEED_1G=2'b10.
  - The state enum.
  - The speed-normalise function.
- Sub-module rgmii_speed_ctrl_timer: one loadable down-counter shared by DRAIN timeout, HOLD and SETTLE.
  - Inputs: load, load value, enable.
  - Output: expired.
  - Width clog2(max(DRAIN_TIMEOUT, SETTLE_CYCLES, RST_CYCLES)+1).

Test Plan:
1. Reset, then idle ~10 cycles -> speed=2'b10, phy_if_rst=0 and mac_tx_hold=0 from the 1st clock after rst_n rises, busy=0.
2. Idle MAC (tx_en=0, clk_en=1), request 2'b00 accepted at cycle N:
   - phy_if_rst=1 at N+2..N+4.
   - speed=00 at N+5.
   - done at N+21, switch_count=1.
3. Request 2'b11 while speed=2'b10 -> done at N+1, busy never 1, switch_count unchanged.
4. mac_tx_en=1 for 100 cycles after accept -> state stays DRAIN, phy_if_rst=0; HOLD begins the cycle after tx_en=0 with clk_en=1.
5. DRAIN_TIMEOUT=64, tx_en stuck at 1 -> timeout_err pulses once after 64 DRAIN cycles, speed still switches, done follows.
6. Assert rst_n=0 during SETTLE -> same-cycle (asynchronous) return to reset values: speed=RESET_SPEED, no done pulse. With RGMII_SPEED_STATS_EN, the counter sum equals cyc_total throughout the run.
